arq_tx_ctrl: RTL

Stop-and-wait ARQ transmit controller that sequences the 4-bit frame FIFO toward the channel. It pops one frame and presents it to the channel with a valid/ready handshake. It then waits for an ack or nack, or for a timeout, and retransmits until a retry limit is reached. It sits between the FIFO read port and the channel/error-injection path inside the top-level TX wrapper.

---
 rtl/arq_tx_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/arq_tx_ctrl.sv
// Stop-and-wait ARQ transmit controller: pops one frame from the FIFO, sends it,
// waits for ack/nack/timeout and retransmits up to MAX_RETRY times before dropping it.
module arq_tx_ctrl #(
    parameter int DATA_WIDTH = 4,
    parameter int MAX_RETRY  = 3,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  tx_valid,
    output logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_ready,
    input  logic                  ack,
    input  logic                  nack,
    output logic                  busy,
    output logic [2:0]            retry_cnt,
    output logic                  done,
    output logic                  fail,
    output logic [7:0]            frames_ok,
    output logic [7:0]            frames_fail
);

    typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT} state_t;

    localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    state_t                state;
    logic [DATA_WIDTH-1:0] frame_q;
    logic [7:0]            timer;
    logic                  resp_ack;
    logic                  attempt_fail;

    // nack wins over a simultaneous ack; ack wins over a simultaneous timeout.
    assign resp_ack     = ack && !nack;
    assign attempt_fail = nack || (timer == TIMER_LAST);

    // Pop request is gated by reset so every output reads 0 while rst_n is low.
    assign fifo_rd_en = rst_n && (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            frame_q     <= '0;
            timer       <= '0;
            retry_cnt   <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            frames_ok   <= '0;
            frames_fail <= '0;
        end else begin
            done <= 1'b0;
            fail <= 1'b0;
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        state <= FETCH;
                        busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    frame_q  <= fifo_data;
                    tx_data  <= fifo_data;
                    tx_valid <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        tx_data  <= '0;
                        timer    <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    timer <= timer + 8'd1;
                    if (resp_ack) begin
                        done      <= 1'b1;
                        frames_ok <= frames_ok + 8'd1;
                        retry_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (attempt_fail) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + 3'd1;
                            tx_valid  <= 1'b1;
                            tx_data   <= frame_q;
                            state     <= SEND;
                        end else begin
                            fail        <= 1'b1;
                            frames_fail <= frames_fail + 8'd1;
                            retry_cnt   <= '0;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
